// File: rtl/cpu_pkg.sv
// Shared types for the instruction prefetch stage: fetch FSM states,
// PC increment and the queued {word, pc} entry.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/cpu_fetch_unit_fifo.sv
// Prefetch queue: synchronous FIFO of fetch entries with flush.
// A flush wins over a simultaneous push and pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fetch_entry_t  i_data,
  output fetch_entry_t  o_data,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_count   = r_count;
  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  // Head reads as zero while empty so stale slots never reach the decoder.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction prefetch stage: issues word fetches over the ins_en/ins_ack
// handshake, queues returned words with their PCs, and handles redirects.
module cpu_fetch_unit
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  input  logic        i_fetch_en,
  input  logic        i_redirect_en,
  input  logic [31:0] i_redirect_pc,
  output logic        o_ins_en,
  output logic [30:0] o_ins_addr,
  input  logic        i_ins_stl,
  input  logic        i_ins_ack,
  input  logic [31:0] i_ins_data,
  output logic        o_dec_valid,
  input  logic        i_dec_ready,
  output logic [31:0] o_dec_word,
  output logic [31:0] o_dec_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  r_state;
  logic [31:0]   r_pc;
  logic          r_ins_en;
  logic [30:0]   r_ins_addr;

  logic          w_ack;
  logic          w_push;
  logic          w_pop;
  logic          w_room;
  logic          w_issue;
  logic [31:0]   w_pc_next;
  logic [31:0]   w_redirect_pc;
  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  fetch_entry_t  w_entry;
  fetch_entry_t  w_head;

  // A completion is only taken while the mru is not signalling busy.
  assign w_ack         = i_ins_ack && !i_ins_stl;
  assign w_push        = (r_state == REQ) && w_ack && !i_redirect_en;
  assign w_pop         = o_dec_valid && i_dec_ready && !i_redirect_en;
  assign w_pc_next     = r_pc + PC_STEP;
  assign w_redirect_pc = i_redirect_pc & ~32'd1;
  assign w_entry       = '{word: i_ins_data, pc: r_pc};

  // Credit: the queue must still have a slot after this cycle's push/pop.
  assign w_room  = w_push ? (w_pop ? !w_full : (w_count < CW'(DEPTH - 1)))
                          : (!w_full || w_pop);
  assign w_issue = i_fetch_en && w_room;

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_ins_en   <= 1'b0;
      r_ins_addr <= RESET_PC[31:1];
    end else begin
      case (r_state)
        IDLE: begin
          if (i_redirect_en) begin
            r_pc <= w_redirect_pc;
          end else if (w_issue) begin
            r_ins_en   <= 1'b1;
            r_ins_addr <= r_pc[31:1];
            r_state    <= REQ;
          end
        end
        REQ: begin
          if (i_redirect_en) begin
            r_pc <= w_redirect_pc;
            if (w_ack) begin
              r_ins_en <= 1'b0;
              r_state  <= IDLE;
            end else begin
              r_state  <= DISCARD;
            end
          end else if (w_ack) begin
            r_pc <= w_pc_next;
            if (w_issue) begin
              r_ins_addr <= w_pc_next[31:1];
            end else begin
              r_ins_en <= 1'b0;
              r_state  <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (i_redirect_en) r_pc <= w_redirect_pc;
          if (w_ack) begin
            r_ins_en <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_ins_en <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_sys_clk),
    .i_rst_n (i_sys_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect_en),
    .i_data  (w_entry),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign o_ins_en    = r_ins_en;
  assign o_ins_addr  = r_ins_addr;
  assign o_dec_valid = !w_empty;
  assign o_dec_word  = w_head.word;
  assign o_dec_pc    = w_head.pc;

endmodule

// File: doc/cpu_fetch_unit.md
Name: cpu_fetch_unit

Overview:
Instruction prefetch stage that sits directly upstream of the mru instruction port. It holds the PC, issues word fetches through the mru ins_en/ins_ack handshake, and buffers returned words with their PCs in a small queue. It presents them to the decoder via valid/ready. Branch/trap redirects flush the queue and discard any in-flight fetch.

Parameters:
DEPTH, 4, prefetch queue entries (power of two, >=2)
RESET_PC, 32'h00000000, PC loaded on reset (bit 0 must be 0)

Ports:
sys_clk  in  1  core clock; all state updates on rising edge
sys_rst  in  1  asynchronous, active-low reset
fetch_en  in  1  permit issuing new fetches; an outstanding fetch always completes
redirect_en  in  1  one-cycle pulse: flush and restart at redirect_pc
redirect_pc  in  32  new PC; bit 0 ignored
ins_en  out  1  fetch request to mru
ins_addr  out  31  halfword address to mru (PC[31:1])
ins_stl  in  1  mru busy; request must be held
ins_ack  in  1  fetch complete; ins_data valid this cycle
ins_data  in  32  fetched instruction word
dec_valid  out  1  queue head valid
dec_ready  in  1  decoder accepts head
dec_word  out  32  head instruction word
dec_pc  out  32  head PC

Behaviour:
- Reset (sys_rst=0, async): pc=RESET_PC; ins_en=0; ins_addr=RESET_PC[31:1]; queue empty; dec_valid=0; dec_word=0; dec_pc=0; state IDLE.
- mru integration: mru ins_ext tied 0. Each fetch returns 32 bits; the PC advances by 4 per word.
- Handshake: once ins_en rises, ins_en and ins_addr stay stable until the cycle ins_ack=1. ins_stl only extends the wait and never cancels the request. At most one fetch is outstanding.
- Credit: a fetch is issued only when fetch_en=1 and count < DEPTH. A slot freed by a pop in the same cycle counts, so issue is allowed when count==DEPTH and a pop occurs.
- States:
  - IDLE: if issue permitted, drive ins_en=1 and ins_addr=pc[31:1] on the next edge; go to REQ.
  - REQ: on ins_ack, push {ins_data, pc}, pc+=4. Next cycle: if still permitted, re-issue back-to-back (ins_en stays 1 with the new address); otherwise go to IDLE.
  - DISCARD: entered when a redirect arrives in REQ without ack. ins_en and the old addr are held; on ack, the data is dropped, ins_en deasserts, go to IDLE. The pc already holds the redirect target.
- Redirect in any state:
  - Queue cleared (count=0, dec_valid=0 next cycle); pc=redirect_pc & ~1.
  - In IDLE: the new fetch may be issued the following cycle (ins_en=1, addr=new pc[31:1]).
  - Redirect and ins_ack in the same cycle in REQ: the data is discarded, no push, go to IDLE (not DISCARD).
  - Redirect in DISCARD: only pc updates.
- Pop: when dec_valid & dec_ready, the head is removed. Push and pop in the same cycle keep count unchanged. Redirect overrides both push and pop.
- Latency:
  - Data acked at edge N gives dec_valid=1 after edge N, with word and PC of that fetch.
  - Redirect at edge N gives ins_en with the new address after edge N+1 (when nothing is outstanding).
- pc wraps modulo 2^32 (0xFFFFFFFC+4 = 0).
- fetch_en=0 in REQ: the current fetch completes and is pushed; no new issue.
- Queue pointers are log2(DEPTH) bits and wrap. count is log2(DEPTH)+1 bits. Overflow is impossible by credit rule; the bench asserts it.

Decomposition:
- Shared package cpu_pkg: fetch_state_t enum {IDLE, REQ, DISCARD}; PC_STEP=4; the fetch_entry_t struct {word[31:0], pc[31:0]}.
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t, DEPTH entries, with push/pop/flush and count/empty/full outputs, same clock/reset.

Test Plan:
- Reset release, mem slave acks 1 cycle after ins_en, dec_ready=1 -> dec_pc sequence 0x0,0x4,0x8,0xC; ins_addr 0x0,0x2,0x4,0x6; dec_word matches memory.
- dec_ready=0, DEPTH=4 -> exactly 4 fetches issued, then ins_en=0. Raise dec_ready -> fetching resumes, no lost or duplicated PCs.
- Hold ins_stl=1 for 5 cycles mid-fetch -> ins_en/ins_addr constant, a single push on ack.
- Redirect to 0x100 while fetch of 0x8 is outstanding -> 0x8 data dropped, next dec_pc=0x100, ins_addr=0x80, queue empty for at least one cycle.
- Redirect in the same cycle as ins_ack for 0x4 -> no entry for 0x4; redirect_pc=0x201 yields dec_pc=0x200.
- Reset asserted mid-REQ -> all outputs at reset values immediately (async), fetch restarts at RESET_PC after release.
